pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- PWM capture/demodulator: measures high time and period of an incoming PWM waveform in clk1 cycles.
- It is the reading end of the PWM sine generator's pwm_out. It is used for loopback self-test and for recovering the duty-cycle code, which can be reported over the UART path.
- Publishes one (duty, period) sample per complete PWM cycle with a single-cycle valid strobe.

Parameters:
- CNT_W, 16, width of the duty and period counters and outputs.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (minimum 2).

Ports:
- clk1  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; 0 forces IDLE.
- pwm_in  input  1  asynchronous PWM input.
- duty  output  CNT_W  clk1 cycles the input was high in the last complete PWM cycle.
- period  output  CNT_W  clk1 cycles between the last two rising edges.
- sample_valid  output  1  one-cycle pulse when duty and period update.
- timeout  output  1  sticky flag: no edge within 2^CNT_W-1 cycles.
- level  output  1  synchronised input level; meaningful while timeout=1 (0%/100% duty).

Behaviour:
- Reset: synchronous, active-high; rst=1 is sampled on clk1.
  - Reset values: duty=0, period=0, sample_valid=0, timeout=0, level=0.
  - Synchroniser flops, counters and latches are cleared; state is IDLE.
  - Reset mid-measurement discards the partial cycle.
- Input path: SYNC_STAGES flops, then one edge-detect flop.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Counts are differences between synchronised edges, so the synchroniser latency does not affect measured values.
- FSM states:
  - IDLE: counters held at 0. Leave to ARM when en=1.
  - ARM: the first partial cycle is discarded. On rise, go to HIGH with per_cnt=1 and hi_cnt=1.
  - HIGH: per_cnt and hi_cnt increment each cycle. On fall, latch hi_lat=hi_cnt, increment per_cnt, go to LOW.
  - LOW: per_cnt increments each cycle. On rise, take the publish action below.
- Publish (rise while in LOW):
  - Register duty<=hi_lat and period<=per_cnt.
  - sample_valid=1 on the next cycle, for exactly one cycle.
  - Reload per_cnt=1 and hi_cnt=1; stay in HIGH.
- Example: input high 3 cycles, low 5 cycles -> duty=3, period=8.
- Saturation: if per_cnt reaches 2^CNT_W-1 in HIGH, LOW or ARM:
  - Set timeout=1 and go to ARM.
  - level continuously mirrors the synchronised input.
  - duty and period hold their last values.
  - timeout clears on the cycle sample_valid next pulses.
  - Counters never wrap.
- Glitch handling: rise and fall in adjacent cycles is legal; a 1-cycle pulse gives hi_cnt=1.
- en deassert in any state: go to IDLE next cycle and discard the partial measurement.
  - sample_valid is not asserted.
  - duty, period and timeout hold their values.
- en re-assert: restart from ARM.
- Simultaneous rst and en: rst wins.

Optional Feature:
- Macro: PWM_CAPTURE_AVG_EN.
- Defined:
  - duty and period are the mean of the last 4 complete cycles.
  - Each field uses a CNT_W+2-bit accumulator and a right shift by 2, truncated.
  - sample_valid pulses once per 4 raw samples.
  - The accumulators clear on rst, en=0 and timeout.
- Undefined: every complete cycle is published, and no accumulator logic exists.

Decomposition:
- Shared header pwm_capture_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, ARM=2'd1, HIGH=2'd2, LOW=2'd3.
  - Default CNT_W.
  - Localparam AVG_SHIFT=2.
- Sub-module pwm_edge_sync:
  - Synchroniser chain plus edge detector.
  - Outputs: s, rise, fall.
  - Reused later for the sw_0/sw_1 inputs.

Test Plan:
1. en=1, periodic 3-high/5-low pattern -> first sample_valid after the second rise; duty=3, period=8; then valid every 8 cycles.
2. en=1, pattern switched mid-run from 3/5 to 6/2 -> one sample of 3/8, then 6/8; no spurious valid at the switch.
3. CNT_W=8, pwm_in held 1 -> timeout=1 and level=1 after 255 cycles; duty/period unchanged; a later 2/2 pattern clears timeout with the first valid.
4. en dropped during HIGH -> no sample_valid; duty/period hold; en re-raised -> first valid only after two full rises.
5. rst=1 for one cycle mid-LOW -> all outputs 0 next cycle; FSM in IDLE; measurement restarts cleanly.
6. With PWM_CAPTURE_AVG_EN, periods 8,8,12,12 with duty 4 each -> single valid with period=10, duty=4.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
//==============================================================================
// Module      : pwm_capture_pkg
// Description : Shared definitions for the PWM capture block: FSM state
//               encodings, default counter width and the averaging shift.
// Revision    : 1.0 - initial release
//==============================================================================
package pwm_capture_pkg;

    // Default width of the duty/period counters and outputs
    localparam int unsigned c_cnt_w_default = 16;

    // Right shift applied to the 4-sample accumulators (divide by 4)
    localparam int unsigned c_avg_shift = 2;

    // Capture FSM state encodings
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_high = 2'd2;
    localparam logic [1:0] c_st_low  = 2'd3;

endpackage : pwm_capture_pkg
`default_nettype wire

// File: rtl/pwm_capture_edge_sync.sv
`default_nettype none
//==============================================================================
// Module      : pwm_edge_sync
// Description : Multi-flop synchroniser for an asynchronous input followed by
//               a single edge-detect flop. Produces the synchronised level and
//               one-cycle rise/fall strobes.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               i_async - asynchronous input
//               s       - synchronised level
//               rise    - synchronised 0->1 transition strobe
//               fall    - synchronised 1->0 transition strobe
// Revision    : 1.0 - initial release
//==============================================================================
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2     // must be 2 or more
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = r_sync[SYNC_STAGES-1] & ~r_s_d;
    assign fall = ~r_sync[SYNC_STAGES-1] & r_s_d;

endmodule : pwm_edge_sync
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
//==============================================================================
// Module      : pwm_capture
// Description : PWM capture/demodulator. Measures high time (duty) and period
//               of an asynchronous PWM input in clk1 cycles and publishes one
//               sample per complete PWM cycle with a single-cycle strobe.
//               Optional build macro PWM_CAPTURE_AVG_EN publishes the mean of
//               every 4 complete cycles instead of each cycle.
// Ports       : clk1         - system clock
//               rst          - synchronous active-high reset
//               en           - capture enable (0 returns to IDLE)
//               pwm_in       - asynchronous PWM input
//               duty         - high cycles of the last complete PWM cycle
//               period       - cycles between the last two rising edges
//               sample_valid - one-cycle pulse when duty/period update
//               timeout      - sticky: no edge within 2^CNT_W-1 cycles
//               level        - synchronised input level
// Revision    : 1.0 - initial release
//==============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w_default,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             sample_valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_hi_lat;
    logic             w_sat;
    logic             w_sat_evt;
    logic             w_start;
    logic             w_publish;
    logic             w_latch_hi;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_timeout;

    pwm_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk     (clk1),
        .rst     (rst),
        .i_async (pwm_in),
        .s       (w_s),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    assign w_sat = (r_per_cnt == c_cnt_max);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next state. Saturation beats an edge in HIGH/LOW because the
    // period would no longer be representable; in ARM a rise still starts
    // a measurement.
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: w_next_state = c_st_arm;
                c_st_arm: begin
                    if (w_rise) w_next_state = c_st_high;
                end
                c_st_high: begin
                    if (w_sat)       w_next_state = c_st_arm;
                    else if (w_fall) w_next_state = c_st_low;
                end
                c_st_low: begin
                    if (w_sat)       w_next_state = c_st_arm;
                    else if (w_rise) w_next_state = c_st_high;
                end
                default: w_next_state = c_st_idle;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // FSM: control strobes for the datapath
    //--------------------------------------------------------------------------
    always_comb begin
        w_sat_evt  = 1'b0;
        w_start    = 1'b0;
        w_publish  = 1'b0;
        w_latch_hi = 1'b0;
        if (en) begin
            case (r_state)
                c_st_arm: begin
                    if (w_rise)     w_start   = 1'b1;
                    else if (w_sat) w_sat_evt = 1'b1;
                end
                c_st_high: begin
                    if (w_sat)       w_sat_evt  = 1'b1;
                    else if (w_fall) w_latch_hi = 1'b1;
                end
                c_st_low: begin
                    if (w_sat) begin
                        w_sat_evt = 1'b1;
                    end else if (w_rise) begin
                        w_publish = 1'b1;
                        w_start   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Period / high-time counters. A rise reloads to 1 because the rise
    // cycle itself is the first cycle of the new PWM period.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (!en || (r_state == c_st_idle) || w_sat_evt) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else if (w_start) begin
            r_per_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_hi_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_per_cnt <= r_per_cnt + 1'b1;
            if ((r_state == c_st_high) && !w_latch_hi) begin
                r_hi_cnt <= r_hi_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_hi_lat <= '0;
        end else if (w_latch_hi) begin
            r_hi_lat <= r_hi_cnt;
        end
    end

`ifdef PWM_CAPTURE_AVG_EN
    //--------------------------------------------------------------------------
    // Averaged publish: sum 4 raw samples, publish the truncated mean.
    //--------------------------------------------------------------------------
    logic [CNT_W+1:0] r_acc_duty;
    logic [CNT_W+1:0] r_acc_per;
    logic [1:0]       r_acc_n;
    logic [CNT_W+1:0] w_sum_duty;
    logic [CNT_W+1:0] w_sum_per;

    assign w_sum_duty = r_acc_duty + {2'b00, r_hi_lat};
    assign w_sum_per  = r_acc_per  + {2'b00, r_per_cnt};

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_acc_duty <= '0;
            r_acc_per  <= '0;
            r_acc_n    <= 2'd0;
            r_duty     <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en || w_sat_evt) begin
                r_acc_duty <= '0;
                r_acc_per  <= '0;
                r_acc_n    <= 2'd0;
                if (w_sat_evt) r_timeout <= 1'b1;
            end else if (w_publish) begin
                if (r_acc_n == 2'd3) begin
                    r_duty     <= CNT_W'(w_sum_duty >> c_avg_shift);
                    r_period   <= CNT_W'(w_sum_per >> c_avg_shift);
                    r_valid    <= 1'b1;
                    r_timeout  <= 1'b0;
                    r_acc_duty <= '0;
                    r_acc_per  <= '0;
                    r_acc_n    <= 2'd0;
                end else begin
                    r_acc_duty <= w_sum_duty;
                    r_acc_per  <= w_sum_per;
                    r_acc_n    <= r_acc_n + 2'd1;
                end
            end
        end
    end
`else
    //--------------------------------------------------------------------------
    // Direct publish: every complete PWM cycle updates the outputs.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_duty    <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_publish) begin
                r_duty    <= r_hi_lat;
                r_period  <= r_per_cnt;
                r_valid   <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_sat_evt) begin
                r_timeout <= 1'b1;
            end
        end
    end
`endif

    assign duty         = r_duty;
    assign period       = r_period;
    assign sample_valid = r_valid;
    assign timeout      = r_timeout;
    assign level        = w_s;

endmodule : pwm_capture
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
//==============================================================================
// Module      : tb_pwm_capture
// Description : Self-checking bench for pwm_capture (CNT_W=8). Drives PWM
//               segments, predicts published samples from segment lengths and
//               compares every sample_valid pulse plus reset, hold and timeout
//               behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pwm_capture;

    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          en;
    logic          pwm_in;
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
    logic          sample_valid;
    logic          timeout;
    logic          level;

    int total;
    int bad;

    // Reference model state
    int q_d[$];
    int q_p[$];
    int cur_h;
    int cur_l;
    bit in_seg;
    int acc_d;
    int acc_p;
    int acc_n;
    int last_d;
    int last_p;

    pwm_capture #(
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .en           (en),
        .pwm_in       (pwm_in),
        .duty         (duty),
        .period       (period),
        .sample_valid (sample_valid),
        .timeout      (timeout),
        .level        (level)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic m_clear_run();
        in_seg = 1'b0;
        acc_d  = 0;
        acc_p  = 0;
        acc_n  = 0;
    endtask

    // A finished PWM cycle of high time h and length p
    task automatic m_publish(input int h, input int p);
`ifdef PWM_CAPTURE_AVG_EN
        acc_d += h;
        acc_p += p;
        acc_n++;
        if (acc_n == 4) begin
            q_d.push_back(acc_d / 4);
            q_p.push_back(acc_p / 4);
            last_d = acc_d / 4;
            last_p = acc_p / 4;
            acc_d  = 0;
            acc_p  = 0;
            acc_n  = 0;
        end
`else
        q_d.push_back(h);
        q_p.push_back(p);
        last_d = h;
        last_p = p;
`endif
    endtask

    // A rising edge closes the previous measured cycle (if any)
    task automatic m_seg_start(input int h);
        if (in_seg) begin
            if (cur_h + cur_l >= MAXC) begin
                acc_d = 0;
                acc_p = 0;
                acc_n = 0;
            end else begin
                m_publish(cur_h, cur_h + cur_l);
            end
        end
        in_seg = 1'b1;
        cur_h  = h;
        cur_l  = 0;
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic seg(input int h, input int l);
        m_seg_start(h);
        pwm_in = 1'b1;
        repeat (h) step();
        pwm_in = 1'b0;
        cur_l  = l;
        repeat (l) step();
    endtask

    task automatic idle(input int n);
        pwm_in = 1'b0;
        repeat (n) step();
        cur_l += n;
    endtask

    task automatic hi_hold(input int n);
        pwm_in = 1'b1;
        repeat (n) step();
        cur_h += n;
    endtask

    task automatic drain(input string tag);
        idle(8);
        chk(tag, 32'(q_d.size()), 0);
    endtask

    // Every strobe must match the oldest predicted sample
    always @(negedge clk1) begin : p_mon
        int ed;
        int ep;
        if (sample_valid === 1'b1) begin
            chk("valid_expected", 32'(q_d.size() != 0), 1);
            chk("valid_timeout_clr", 32'(timeout), 0);
            if (q_d.size() != 0) begin
                ed = q_d.pop_front();
                ep = q_p.pop_front();
                chk("sample_duty", 32'(duty), ed);
                chk("sample_period", 32'(period), ep);
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        cur_h  = 0;
        cur_l  = 0;
        last_d = 0;
        last_p = 0;
        m_clear_run();
        repeat (3) step();
        chk("rst_duty", 32'(duty), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_level", 32'(level), 0);

        rst = 1'b0;
        en  = 1'b1;
        idle(4);

        // Steady 3-high / 5-low
        repeat (5) seg(3, 5);
        drain("drain_steady");

        // Pattern change 3/5 -> 6/2
        repeat (2) seg(3, 5);
        repeat (3) seg(6, 2);
        drain("drain_switch");

        // Random patterns including 1-cycle pulses and gaps
        repeat (24) seg(int'($urandom_range(7, 1)), int'($urandom_range(7, 1)));
        drain("drain_random");

        // Enable dropped during HIGH
        seg(3, 5);
        seg(3, 5);
        seg(6, 0);
        en = 1'b0;
        m_clear_run();
        step();
        pwm_in = 1'b0;
        repeat (6) step();
        chk("endrop_duty", 32'(duty), last_d);
        chk("endrop_period", 32'(period), last_p);
        chk("endrop_valid", 32'(sample_valid), 0);
        chk("endrop_queue", 32'(q_d.size()), 0);
        en = 1'b1;
        repeat (4) step();
        repeat (4) seg(2, 3);
        drain("drain_reenable");

        // Reset mid-LOW with en held high
        seg(3, 5);
        seg(3, 4);
        rst = 1'b1;
        step();
        m_clear_run();
        last_d = 0;
        last_p = 0;
        chk("midrst_duty", 32'(duty), 0);
        chk("midrst_period", 32'(period), 0);
        chk("midrst_valid", 32'(sample_valid), 0);
        chk("midrst_timeout", 32'(timeout), 0);
        chk("midrst_level", 32'(level), 0);
        rst = 1'b0;
        idle(3);

        // Periods 8,8,12,12 with duty 4
        seg(4, 4);
        seg(4, 4);
        seg(4, 8);
        seg(4, 8);
        seg(3, 3);
        drain("drain_avg");
`ifdef PWM_CAPTURE_AVG_EN
        chk("avg_period", 32'(period), 10);
`else
        chk("avg_period", 32'(period), 12);
`endif
        chk("avg_duty", 32'(duty), 4);

        // Input stuck high -> timeout, then recovery with 2/2
        seg(3, 3);
        seg(200, 0);
        chk("pre_timeout", 32'(timeout), 0);
        hi_hold(100);
        chk("timeout_set", 32'(timeout), 1);
        chk("timeout_level", 32'(level), 1);
        chk("timeout_duty_hold", 32'(duty), last_d);
        chk("timeout_period_hold", 32'(period), last_p);
        idle(2);
        repeat (6) seg(2, 2);
        drain("drain_recover");
        chk("timeout_cleared", 32'(timeout), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pwm_capture
`default_nettype wire
